// File: rtl/riscv_multicycle.sv
// Multicycle RV32I-subset core: add/sub/xor/sll/srl/addi/lw/sw/beq/bne.
// Each instruction walks FETCH -> DECODE -> EXEC [-> MEM] [-> WB].
// Data memory and register file are internal. Illegal encodings and misaligned
// accesses park the core in HALT until reset.
module riscv_multicycle #(
   parameter int XLEN = 32,
   parameter int NREGS = 32,
   parameter int DMEM_WORDS = 64,
   parameter logic [XLEN-1:0] PC_RESET = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     instr_valid,
   input  logic [31:0]              instr,
   output logic                     instr_ready,
   output logic [XLEN-1:0]          pc,
   output logic                     retire,
   output logic                     illegal,
   input  logic [$clog2(NREGS)-1:0] dbg_raddr,
   output logic [XLEN-1:0]          dbg_rdata
);

   localparam int RW = $clog2(NREGS);
   localparam int DW = $clog2(DMEM_WORDS);
   localparam int SW = $clog2(XLEN);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRL, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE
   } op_t;

   state_t state_q, state_d;
   op_t    op_q, decOp;

   logic [31:0]     instr_q;
   logic [XLEN-1:0] regs_q [NREGS];
   logic [31:0]     dmem_q [DMEM_WORDS];
   logic [XLEN-1:0] pc_q, rs1Val_q, rs2Val_q, imm_q, addr_q, result_q;

   logic [XLEN-1:0] decImm, aluResult, memAddr, pcPlus4;
   logic            decLegal, usesRs1, usesRs2, usesRd;
   logic            branchTaken, misaligned;
   logic            instrReady, retireRaw, illegalOut;
   logic [DW-1:0]   dmemIdx;
   logic            unusedAddrBits;

   logic [6:0] opcode, funct7;
   logic [4:0] rdField, rs1Field, rs2Field;
   logic [2:0] funct3;

   assign opcode   = instr_q[6:0];
   assign rdField  = instr_q[11:7];
   assign funct3   = instr_q[14:12];
   assign rs1Field = instr_q[19:15];
   assign rs2Field = instr_q[24:20];
   assign funct7   = instr_q[31:25];

   assign dmemIdx        = addr_q[2 +: DW];
   assign unusedAddrBits = ^addr_q;

   // Classify the latched instruction and build its sign-extended immediate.
   always_comb begin
      decOp    = OP_ADD;
      decLegal = 1'b0;
      decImm   = '0;
      usesRs1  = 1'b0;
      usesRs2  = 1'b0;
      usesRd   = 1'b0;
      case (opcode)
         7'b0110011: begin
            usesRs1 = 1'b1;
            usesRs2 = 1'b1;
            usesRd  = 1'b1;
            if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000: begin decOp = OP_ADD; decLegal = 1'b1; end
                  3'b100: begin decOp = OP_XOR; decLegal = 1'b1; end
                  3'b001: begin decOp = OP_SLL; decLegal = 1'b1; end
                  3'b101: begin decOp = OP_SRL; decLegal = 1'b1; end
                  default: ;
               endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               decOp    = OP_SUB;
               decLegal = 1'b1;
            end
         end
         7'b0010011: begin
            usesRs1 = 1'b1;
            usesRd  = 1'b1;
            decImm  = XLEN'($signed(instr_q[31:20]));
            if (funct3 == 3'b000) begin
               decOp    = OP_ADDI;
               decLegal = 1'b1;
            end
         end
         7'b0000011: begin
            usesRs1 = 1'b1;
            usesRd  = 1'b1;
            decImm  = XLEN'($signed(instr_q[31:20]));
            if (funct3 == 3'b010) begin
               decOp    = OP_LW;
               decLegal = 1'b1;
            end
         end
         7'b0100011: begin
            usesRs1 = 1'b1;
            usesRs2 = 1'b1;
            decImm  = XLEN'($signed({instr_q[31:25], instr_q[11:7]}));
            if (funct3 == 3'b010) begin
               decOp    = OP_SW;
               decLegal = 1'b1;
            end
         end
         7'b1100011: begin
            usesRs1 = 1'b1;
            usesRs2 = 1'b1;
            decImm  = XLEN'($signed({instr_q[31], instr_q[7], instr_q[30:25],
                                     instr_q[11:8], 1'b0}));
            if (funct3 == 3'b000) begin
               decOp    = OP_BEQ;
               decLegal = 1'b1;
            end else if (funct3 == 3'b001) begin
               decOp    = OP_BNE;
               decLegal = 1'b1;
            end
         end
         default: ;
      endcase
      // A 16-entry file cannot name registers 16..31.
      if (NREGS == 16 && ((usesRs1 && rs1Field[4]) || (usesRs2 && rs2Field[4]) ||
                          (usesRd && rdField[4]))) begin
         decLegal = 1'b0;
      end
   end

   // Execute-stage arithmetic, effective address and branch decision.
   always_comb begin
      memAddr     = rs1Val_q + imm_q;
      pcPlus4     = pc_q + XLEN'(4);
      misaligned  = (memAddr[1:0] != 2'b00);
      branchTaken = (op_q == OP_BEQ) ? (rs1Val_q == rs2Val_q) : (rs1Val_q != rs2Val_q);
      aluResult   = memAddr;
      case (op_q)
         OP_ADD:  aluResult = rs1Val_q + rs2Val_q;
         OP_SUB:  aluResult = rs1Val_q - rs2Val_q;
         OP_XOR:  aluResult = rs1Val_q ^ rs2Val_q;
         OP_SLL:  aluResult = rs1Val_q << rs2Val_q[SW-1:0];
         OP_SRL:  aluResult = rs1Val_q >> rs2Val_q[SW-1:0];
         default: aluResult = memAddr;
      endcase
   end

   // Next-state selection and per-state handshake/status outputs.
   always_comb begin
      state_d    = state_q;
      instrReady = 1'b0;
      retireRaw  = 1'b0;
      illegalOut = 1'b0;
      case (state_q)
         S_FETCH: begin
            instrReady = 1'b1;
            if (instr_valid) state_d = S_DECODE;
         end
         S_DECODE: state_d = decLegal ? S_EXEC : S_HALT;
         S_EXEC: begin
            if (op_q == OP_LW || op_q == OP_SW) begin
               state_d = misaligned ? S_HALT : S_MEM;
            end else if (op_q == OP_BEQ || op_q == OP_BNE) begin
               retireRaw = 1'b1;
               state_d   = S_FETCH;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (op_q == OP_SW) begin
               retireRaw = 1'b1;
               state_d   = S_FETCH;
            end else begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            retireRaw = 1'b1;
            state_d   = S_FETCH;
         end
         S_HALT: begin
            illegalOut = 1'b1;
            state_d    = S_HALT;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // A cycle with reset asserted is being aborted, so it neither accepts nor retires.
   assign instr_ready = instrReady & rst;
   assign retire      = retireRaw & rst;
   assign illegal     = illegalOut;
   assign pc          = pc_q;
   assign dbg_rdata   = (dbg_raddr == '0) ? '0 : regs_q[dbg_raddr];

   // Control state register.
   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_FETCH;
      else      state_q <= state_d;
   end

   // Datapath registers, register file and data memory, updated per stage.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q     <= PC_RESET;
         instr_q  <= '0;
         op_q     <= OP_ADD;
         rs1Val_q <= '0;
         rs2Val_q <= '0;
         imm_q    <= '0;
         addr_q   <= '0;
         result_q <= '0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= '0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (instr_valid) instr_q <= instr;
            end
            S_DECODE: begin
               rs1Val_q <= regs_q[rs1Field[RW-1:0]];
               rs2Val_q <= regs_q[rs2Field[RW-1:0]];
               imm_q    <= decImm;
               op_q     <= decOp;
            end
            S_EXEC: begin
               if (op_q == OP_BEQ || op_q == OP_BNE) begin
                  pc_q <= branchTaken ? pc_q + imm_q : pcPlus4;
               end
               result_q <= aluResult;
               addr_q   <= memAddr;
            end
            S_MEM: begin
               if (op_q == OP_SW) begin
                  dmem_q[dmemIdx] <= rs2Val_q[31:0];
                  pc_q            <= pcPlus4;
               end else begin
                  result_q <= XLEN'($signed(dmem_q[dmemIdx]));
               end
            end
            S_WB: begin
               if (rdField != 5'd0) regs_q[rdField[RW-1:0]] <= result_q;
               pc_q <= pcPlus4;
            end
            default: ;
         endcase
      end
   end

endmodule
